eth_mac_tx_framer: RTL and testbench
====================================

// Module: eth_mac_tx_framer
// PURPOSE
//  Ethernet TX MAC framer. Sits directly upstream of the GMII TX adapter and drives its
//  mac_tx_* stream. Takes a raw L2 frame (DA..payload, no FCS) on a ready/valid byte stream.
//  Emits one contiguous byte burst per frame: preamble, SFD, data, zero-pad to minimum length,
//  then the CRC-32 FCS. Enforces the inter-frame gap, and aborts underrun or oversize frames
//  with a deliberately corrupted FCS.
// PARAMETERS
//  MIN_FRAME_LEN  60    min data+pad bytes before FCS; 0 disables padding
//  MAX_FRAME_LEN  1514  max data bytes before FCS; exceeding it is oversize
//  IFG_CYCLES     12    idle cycles (m_tvalid=0) after the last FCS byte
// PORTS
//  clk               in   1   byte clock, shared with the GMII adapter (125 MHz)
//  rst               in   1   synchronous, active-high reset
//  s_tvalid          in   1   upstream byte valid
//  s_tdata           in   8   upstream frame byte
//  s_tlast           in   1   last byte of upstream frame
//  s_tready          out  1   framer accepts s_tdata this cycle
//  m_tvalid          out  1   to mac_tx_tvalid; high for the whole preamble..FCS burst
//  m_tdata           out  8   to mac_tx_tdata
//  m_tlast           out  1   to mac_tx_tlast; high on the final FCS byte only
//  tx_busy           out  1   state != IDLE
//  tx_frame_done     out  1   1-cycle pulse with m_tlast
//  tx_err_underrun   out  1   1-cycle pulse, first FCS byte of an underrun-aborted frame
//  tx_err_oversize   out  1   1-cycle pulse, first FCS byte of an oversize-aborted frame
// BEHAVIOUR
//  Clock/reset: one clock, clk. rst is synchronous and active-high.
//  Reset state: all outputs 0; state IDLE; counters, CRC and flags cleared.
//  Output timing: m_* and status outputs are registered. s_tready is decoded from the
//   registered state.
//  States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DISCARD.
//  IDLE: s_tready=0. s_tvalid=1 in cycle t -> PREAMBLE.
//   Output is m_tdata=0x55 in t+1..t+7, then 0xD5 (SFD) in t+8.
//  DATA: s_tready=1 from cycle t+8 (the SFD output cycle) until frame end.
//   A byte accepted in cycle c appears on m_tdata in c+1, so there is no bubble after SFD.
//  Byte counter: 11 bits, counts data+pad bytes, saturating.
//  CRC-32 coverage: data+pad bytes only.
//  CRC-32 algorithm: reflected, poly 0xEDB88320, init 0xFFFFFFFF. FCS = ~crc.
//   Sent LSB byte first, over 4 cycles.
//  Normal end: s_tlast accepted with count n.
//   If n < MIN_FRAME_LEN: PAD emits MIN_FRAME_LEN-n bytes of 0x00, then FCS.
//   Otherwise: FCS directly after the last byte.
//  After FCS: IFG for IFG_CYCLES cycles with m_tvalid=0, then IDLE.
//   If the last FCS byte is in cycle f, the next preamble starts no earlier than
//   f+IFG_CYCLES+2.
//  Underrun: s_tvalid=0 in any cycle with s_tready=1 (including the SFD cycle).
//   No byte is taken, padding is skipped, and FCS starts next cycle.
//   FCS is sent as crc (NOT inverted), so it is guaranteed bad.
//   tx_err_underrun pulses on FCS byte 0. Upstream must not resume that frame.
//  Oversize: byte number MAX_FRAME_LEN accepted without s_tlast.
//   s_tready drops next cycle, then a bad FCS (as underrun) and tx_err_oversize.
//   Then IFG, then DISCARD: s_tready=1, bytes dropped (m_tvalid=0) until s_tlast accepted,
//   then IDLE.
//  s_tlast together with an oversize count: treated as normal end (the frame fits exactly).
//  m_tvalid: never deasserts between the first preamble byte and m_tlast.
//   This is required because the GMII adapter has no back-pressure.
//  Reset mid-frame: next cycle m_tvalid=0 with no FCS (frame truncated), state IDLE.
//   Upstream is reset together with the framer.
// TESTING
//  1 60-byte frame, bytes 0x00..0x3B, s_tvalid held ->
//    7x0x55, 0xD5, 60 data bytes, 4 FCS bytes; m_tlast on byte 72; tx_frame_done=1 once.
//  2 MIN_FRAME_LEN=0, ASCII "123456789" ->
//    FCS bytes 0x26,0x39,0xF4,0xCB; m_tvalid contiguous for 21 cycles.
//  3 14-byte frame (default params) ->
//    46x 0x00 pad after the data; FCS matches a reference CRC over 60 bytes.
//  4 Drop s_tvalid after 20 accepted bytes ->
//    next cycle FCS byte 0 = ~(good FCS byte 0); tx_err_underrun=1; 4 FCS bytes, then IFG.
//  5 Back-to-back frames, s_tvalid held ->
//    exactly 12 idle cycles between m_tlast and the next 0x55 (+1 IDLE sample cycle).
//  6 MAX_FRAME_LEN=64, 100-byte frame ->
//    64 data bytes, bad FCS, tx_err_oversize; remaining 36 bytes consumed in DISCARD;
//    next frame normal.

Source files
------------

// File: rtl/eth_mac_tx_framer.sv
// eth_mac_tx_framer: Ethernet TX framer that adds preamble/SFD, pads to minimum length, appends FCS and enforces IFG
// Ports:
//   clk, rst                      byte clock, synchronous active-high reset
//   s_tvalid/s_tdata/s_tlast      upstream raw L2 frame bytes (DA..payload, no FCS)
//   s_tready                      byte taken this cycle (decoded from registered state)
//   m_tvalid/m_tdata/m_tlast      registered burst to the GMII adapter, contiguous preamble..FCS
//   tx_busy                       framer not idle
//   tx_frame_done                 pulse with m_tlast
//   tx_err_underrun/oversize      pulse with the first byte of a deliberately bad FCS
module eth_mac_tx_framer #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int MAX_FRAME_LEN = 1514,
    parameter int IFG_CYCLES    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tvalid,
    input  logic [7:0] s_tdata,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       m_tvalid,
    output logic [7:0] m_tdata,
    output logic       m_tlast,
    output logic       tx_busy,
    output logic       tx_frame_done,
    output logic       tx_err_underrun,
    output logic       tx_err_oversize
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [15:0] sub_q, sub_d;
    logic [31:0] crc_q, crc_d;
    logic        bad_q, bad_d, ovs_q, ovs_d;
    logic        m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
    logic [7:0]  m_tdata_q, m_tdata_d;
    logic        done_q, done_d, eu_q, eu_d, eo_q, eo_d;
    logic [31:0] fcs_word;
    logic [10:0] cnt_inc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // Aborted frames send the running CRC uninverted so the receiver is sure to reject them.
    assign fcs_word = bad_q ? crc_q : ~crc_q;
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + 11'd1;

    assign s_tready        = (state_q == DATA) || (state_q == DISCARD);
    assign tx_busy         = state_q != IDLE;
    assign m_tvalid        = m_tvalid_q;
    assign m_tdata         = m_tdata_q;
    assign m_tlast         = m_tlast_q;
    assign tx_frame_done   = done_q;
    assign tx_err_underrun = eu_q;
    assign tx_err_oversize = eo_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        crc_d      = crc_q;
        bad_d      = bad_q;
        ovs_d      = ovs_q;
        m_tvalid_d = 1'b0;
        m_tdata_d  = 8'h00;
        m_tlast_d  = 1'b0;
        done_d     = 1'b0;
        eu_d       = 1'b0;
        eo_d       = 1'b0;
        case (state_q)
            IDLE: if (s_tvalid) begin
                state_d    = PREAMBLE;
                sub_d      = '0;
                cnt_d      = '0;
                crc_d      = '1;
                bad_d      = 1'b0;
                ovs_d      = 1'b0;
                m_tvalid_d = 1'b1;
                m_tdata_d  = 8'h55;
            end
            PREAMBLE: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = sub_q == 16'd6 ? 8'hD5 : 8'h55;
                sub_d      = sub_q + 16'd1;
                if (sub_q == 16'd6) state_d = DATA;
            end
            DATA: begin
                m_tvalid_d = 1'b1;
                if (s_tvalid) begin
                    m_tdata_d = s_tdata;
                    crc_d     = crc_byte(crc_q, s_tdata);
                    cnt_d     = cnt_inc;
                    sub_d     = '0;
                    if (s_tlast) begin
                        state_d = ({1'b0, cnt_q} + 12'd1 < 12'(MIN_FRAME_LEN)) ? PAD : FCS;
                    end else if (cnt_q == 11'(MAX_FRAME_LEN - 1)) begin
                        state_d = FCS;
                        bad_d   = 1'b1;
                        ovs_d   = 1'b1;
                    end
                end else begin
                    // Underrun: FCS byte 0 goes out immediately so the burst stays contiguous.
                    m_tdata_d = crc_q[7:0];
                    eu_d      = 1'b1;
                    bad_d     = 1'b1;
                    state_d   = FCS;
                    sub_d     = 16'd1;
                end
            end
            PAD: begin
                m_tvalid_d = 1'b1;
                crc_d      = crc_byte(crc_q, 8'h00);
                cnt_d      = cnt_inc;
                sub_d      = '0;
                if ({1'b0, cnt_q} + 12'd1 >= 12'(MIN_FRAME_LEN)) state_d = FCS;
            end
            FCS: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = fcs_word[{sub_q[1:0], 3'b000} +: 8];
                eo_d       = ovs_q && sub_q == 16'd0;
                m_tlast_d  = sub_q == 16'd3;
                done_d     = sub_q == 16'd3;
                sub_d      = sub_q == 16'd3 ? 16'd0 : sub_q + 16'd1;
                if (sub_q == 16'd3) state_d = IFG;
            end
            IFG: begin
                // One cycle longer than IFG_CYCLES: IDLE still needs a cycle to see s_tvalid.
                sub_d = sub_q + 16'd1;
                if (sub_q == 16'(IFG_CYCLES)) state_d = ovs_q ? DISCARD : IDLE;
            end
            DISCARD: if (s_tvalid && s_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sub_q      <= '0;
            crc_q      <= '0;
            bad_q      <= 1'b0;
            ovs_q      <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 8'h00;
            m_tlast_q  <= 1'b0;
            done_q     <= 1'b0;
            eu_q       <= 1'b0;
            eo_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            crc_q      <= crc_d;
            bad_q      <= bad_d;
            ovs_q      <= ovs_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            done_q     <= done_d;
            eu_q       <= eu_d;
            eo_q       <= eo_d;
        end
    end
endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// tb_eth_mac_tx_framer: frame-level model of the TX framer checked against two DUT configurations
module tb_eth_mac_tx_framer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic s_tvalid = 1'b0, s_tlast = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    always #4 clk = ~clk;

    logic a_rdy, a_mv, a_ml, a_busy, a_done, a_eu, a_eo;
    logic b_rdy, b_mv, b_ml, b_busy, b_done, b_eu, b_eo;
    logic [7:0] a_md, b_md;
    logic rdy, mv, ml, busy, done, eu, eo;
    logic [7:0] md;

    eth_mac_tx_framer u_a (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid & ~sel), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(a_rdy), .m_tvalid(a_mv), .m_tdata(a_md), .m_tlast(a_ml), .tx_busy(a_busy),
        .tx_frame_done(a_done), .tx_err_underrun(a_eu), .tx_err_oversize(a_eo));

    eth_mac_tx_framer #(.MIN_FRAME_LEN(0), .MAX_FRAME_LEN(64)) u_b (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid & sel), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(b_rdy), .m_tvalid(b_mv), .m_tdata(b_md), .m_tlast(b_ml), .tx_busy(b_busy),
        .tx_frame_done(b_done), .tx_err_underrun(b_eu), .tx_err_oversize(b_eo));

    assign rdy  = sel ? b_rdy  : a_rdy;
    assign mv   = sel ? b_mv   : a_mv;
    assign md   = sel ? b_md   : a_md;
    assign ml   = sel ? b_ml   : a_ml;
    assign busy = sel ? b_busy : a_busy;
    assign done = sel ? b_done : a_done;
    assign eu   = sel ? b_eu   : a_eu;
    assign eo   = sel ? b_eo   : a_eo;

    typedef struct packed {logic [7:0] d; logic l; logic eu; logic eo;} ex_t;
    ex_t expq[$];
    logic [7:0]  fb [0:255];
    logic [31:0] crc_tab [0:255];
    int checks = 0, failures = 0;
    int cyc = 0, last_tlast = -1, gap_last = 0, blen = 0, blen_last = 0, done_cnt = 0;
    bit in_burst = 1'b0, chk_en = 1'b0;
    logic [31:0] fcs_sh = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    // Expected burst for one frame: what the wire must carry given how many bytes get taken.
    function automatic void push_frame(input int n, input int stop_at);
        int min_len, max_len, acc, len;
        bit und, ovs;
        logic [31:0] c;
        min_len = sel ? 0 : 60;
        max_len = sel ? 64 : 1514;
        und = stop_at >= 0;
        ovs = !und && n > max_len;
        acc = und ? stop_at : ovs ? max_len : n;
        for (int i = 0; i < 7; i++) expq.push_back(ex_t'{8'h55, 1'b0, 1'b0, 1'b0});
        expq.push_back(ex_t'{8'hD5, 1'b0, 1'b0, 1'b0});
        c = '1;
        len = 0;
        for (int i = 0; i < acc; i++) begin
            expq.push_back(ex_t'{fb[i], 1'b0, 1'b0, 1'b0});
            c = crc_upd(c, fb[i]);
            len++;
        end
        if (!und && !ovs) begin
            while (len < min_len) begin
                expq.push_back(ex_t'{8'h00, 1'b0, 1'b0, 1'b0});
                c = crc_upd(c, 8'h00);
                len++;
            end
            c = ~c;
        end
        for (int k = 0; k < 4; k++)
            expq.push_back(ex_t'{c[8*k +: 8], k == 3, und && k == 0, ovs && k == 0});
    endfunction

    always @(negedge clk) begin
        ex_t e;
        cyc++;
        if (chk_en) begin
            if (mv) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    blen = 0;
                    if (last_tlast >= 0) begin
                        gap_last = cyc - last_tlast;
                        chk("ifg_min_gap", 32'(gap_last >= 14), 32'd1);
                    end
                end
                blen++;
                fcs_sh = {md, fcs_sh[31:8]};
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=no_byte (cycle %0d)", md, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("m_tdata", 32'(md), 32'(e.d));
                    chk("m_tlast", 32'(ml), 32'(e.l));
                    chk("tx_frame_done", 32'(done), 32'(e.l));
                    chk("tx_err_underrun", 32'(eu), 32'(e.eu));
                    chk("tx_err_oversize", 32'(eo), 32'(e.eo));
                    chk("tx_busy_in_burst", 32'(busy), 32'd1);
                end
                if (done) done_cnt++;
                if (ml) begin
                    in_burst = 1'b0;
                    last_tlast = cyc;
                    blen_last = blen;
                end
            end else begin
                chk("burst_contiguous", 32'(in_burst), 32'd0);
                in_burst = 1'b0;
                chk("idle_status", {28'd0, ml, done, eu, eo}, 32'd0);
            end
        end
    end

    task automatic send(input int n, input int stop_at);
        bit ok, r;
        push_frame(n, stop_at);
        for (int i = 0; i < n; i++) begin
            if (stop_at >= 0 && i == stop_at) break;
            s_tvalid = 1'b1;
            s_tdata = fb[i];
            s_tlast = i == n - 1;
            ok = 1'b0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                r = rdy;
                @(posedge clk);
                #1;
                if (r) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk("handshake_timeout", 32'(ok), 32'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (expq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [31:0] c;
        int dc;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
            crc_tab[i] = c;
        end
        c = '1;
        for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
        chk("model_crc_123456789", ~c, 32'hCBF43926);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_outputs", {24'd0, a_rdy, a_mv, a_ml, a_busy, a_done, a_eu, a_eo, 1'b0}, 32'd0);
        chk("rst_a_tdata", 32'(a_md), 32'd0);
        chk("rst_b_outputs", {24'd0, b_rdy, b_mv, b_ml, b_busy, b_done, b_eu, b_eo, 1'b0}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // 60-byte frame, no padding
        for (int i = 0; i < 256; i++) fb[i] = 8'(i);
        dc = done_cnt;
        send(60, -1);
        wait_idle();
        chk("t1_burst_len", 32'(blen_last), 32'd72);
        chk("t1_done_once", 32'(done_cnt - dc), 32'd1);

        // 14-byte frame padded with 46 zeros
        for (int i = 0; i < 256; i++) fb[i] = 8'(i + 8'hA0);
        send(14, -1);
        wait_idle();
        chk("t3_burst_len", 32'(blen_last), 32'd72);

        // underrun after 20 bytes
        for (int i = 0; i < 256; i++) fb[i] = 8'(i * 3);
        send(40, 20);
        wait_idle();
        chk("t4_burst_len", 32'(blen_last), 32'd32);

        // back-to-back frames with s_tvalid held
        for (int i = 0; i < 256; i++) fb[i] = 8'(255 - i);
        send(64, -1);
        send(61, -1);
        wait_idle();
        chk("t5_ifg_exact", 32'(gap_last), 32'd14);

        // MIN_FRAME_LEN=0 instance: check value
        sel = 1'b1;
        for (int i = 0; i < 9; i++) fb[i] = 8'(8'h31 + i);
        send(9, -1);
        wait_idle();
        chk("t2_burst_len", 32'(blen_last), 32'd21);
        chk("t2_fcs_bytes", fcs_sh, 32'hCBF43926);

        // MAX_FRAME_LEN=64 instance: oversize, discard, then normal frames
        for (int i = 0; i < 256; i++) fb[i] = 8'(i);
        send(100, -1);
        wait_idle();
        chk("t6_burst_len", 32'(blen_last), 32'd76);
        send(10, -1);
        wait_idle();
        chk("t6_next_len", 32'(blen_last), 32'd22);
        send(64, -1);
        wait_idle();
        chk("t6_exact_max_len", 32'(blen_last), 32'd76);

        // reset in the middle of a frame truncates it
        sel = 1'b0;
        chk_en = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'h11;
        s_tlast = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_active", {30'd0, mv, busy}, 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {29'd0, mv, busy, rdy}, 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
